msfsm_tb_arbiter: RTL and testbench

MSFSM_TB_ARBITER -- requirements
Module: msfsm_tb_arbiter

---
 rtl/msfsm_pkg.sv | 14 +
 rtl/msfsm_rr_select.sv | 33 +++
 rtl/msfsm_tb_arbiter.sv | 145 ++++++++++++++
 tb/tb_msfsm_tb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/msfsm_pkg.sv
// Shared constants for the MSFSM transition-barrier arbiter slice.
package msfsm_pkg;

  // Upper bounds on the arbitrated transitions and observed places.
  localparam int MSFSM_MAX_TRANS  = 16;
  localparam int MSFSM_MAX_PLACES = 16;

  // Width of the round-robin pointer, sized for MSFSM_MAX_TRANS.
  localparam int MSFSM_PTR_W = $clog2(MSFSM_MAX_TRANS);

  // Width of the stall watchdog counter.
  localparam int MSFSM_WD_W = 16;

endpackage : msfsm_pkg

// File: rtl/msfsm_rr_select.sv
// Round-robin greedy selector: walks the enabled transitions starting at
// rr_ptr_i (wrapping) and keeps each one that conflicts with none already
// kept, yielding a maximal non-conflicting set. Purely combinational.
module msfsm_rr_select
  import msfsm_pkg::*;
#(
  parameter int N_TRANS = 8
) (
  input  logic [N_TRANS-1:0]         enable_i,
  input  logic [N_TRANS*N_TRANS-1:0] conflict_i,
  input  logic [MSFSM_PTR_W-1:0]     rr_ptr_i,
  output logic [N_TRANS-1:0]         select_o
);

  logic [N_TRANS-1:0] sel;

  // Greedy scan in rotated order; row j of conflict_i lists the rivals of j.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it holding its old value and no latch is inferred.
    sel = '0;
    for (int i = 0; i < N_TRANS; i++) begin
      for (int j = 0; j < N_TRANS; j++) begin
        if (((int'(rr_ptr_i) + i) % N_TRANS) == j && enable_i[j] &&
            ((conflict_i[j*N_TRANS +: N_TRANS] & sel) == '0)) begin
          sel[j] = 1'b1;
        end
      end
    end
    select_o = sel;
  end

endmodule : msfsm_rr_select

// File: rtl/msfsm_tb_arbiter.sv
// Transition-barrier arbiter for cooperating FSMs. Grants shared transitions
// whose preset places are all marked, never granting two transitions that
// share a place in one cycle, and locks granted places out for one cycle so
// the still-displayed old marking cannot be granted again.
// Optional stall watchdog: define MSFSM_TB_WATCHDOG_EN to build it.
module msfsm_tb_arbiter
  import msfsm_pkg::*;
#(
  parameter int                          N_TRANS  = 8,
  parameter int                          N_PLACES = 8,
  parameter logic [N_TRANS*N_PLACES-1:0] PRE_MASK = '0,
  parameter int                          WD_LIMIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_PLACES-1:0] place_i,
  input  logic [N_TRANS-1:0]  req_i,
  output logic [N_TRANS-1:0]  tb_grant_o,
  output logic                busy_o,
  output logic                deadlock_o
);

  // Reject out-of-range configurations at elaboration.
  if (N_TRANS < 1 || N_TRANS > MSFSM_MAX_TRANS ||
      N_PLACES < 1 || N_PLACES > MSFSM_MAX_PLACES ||
      WD_LIMIT < 1 || WD_LIMIT > (2**MSFSM_WD_W) - 1) begin : g_bad_param
    $error("msfsm_tb_arbiter: parameter out of range");
  end

  logic [N_TRANS*N_TRANS-1:0] conflict;
  logic [N_TRANS-1:0]         enable;
  logic [N_TRANS-1:0]         select;
  logic [N_PLACES-1:0]        lockout;
  logic [N_PLACES-1:0]        lock_nxt;
  logic [MSFSM_PTR_W-1:0]     rr_ptr;
  logic [MSFSM_PTR_W-1:0]     ptr_nxt;
  logic                       found;

  // Static conflict matrix: t and u conflict when their presets overlap.
  always_comb begin
    conflict = '0;
    for (int t = 0; t < N_TRANS; t++) begin
      for (int u = 0; u < N_TRANS; u++) begin
        conflict[t*N_TRANS + u] = |(PRE_MASK[t*N_PLACES +: N_PLACES] &
                                    PRE_MASK[u*N_PLACES +: N_PLACES]);
      end
    end
  end

  // A transition is enabled when requested, its non-empty preset is fully
  // marked, and none of its preset places is locked out.
  always_comb begin
    enable = '0;
    for (int t = 0; t < N_TRANS; t++) begin
      enable[t] = req_i[t] &&
                  (PRE_MASK[t*N_PLACES +: N_PLACES] != '0) &&
                  ((place_i & PRE_MASK[t*N_PLACES +: N_PLACES]) ==
                   PRE_MASK[t*N_PLACES +: N_PLACES]) &&
                  ((lockout & PRE_MASK[t*N_PLACES +: N_PLACES]) == '0);
    end
  end

  msfsm_rr_select #(
    .N_TRANS (N_TRANS)
  ) u_rr_select (
    .enable_i   (enable),
    .conflict_i (conflict),
    .rr_ptr_i   (rr_ptr),
    .select_o   (select)
  );

  // Places claimed by this cycle's selection become next cycle's lockout.
  always_comb begin
    lock_nxt = '0;
    for (int t = 0; t < N_TRANS; t++) begin
      if (select[t]) lock_nxt = lock_nxt | PRE_MASK[t*N_PLACES +: N_PLACES];
    end
  end

  // The first enabled transition in scan order is always the first one
  // selected; the pointer moves just past it.
  always_comb begin
    ptr_nxt = rr_ptr;
    found   = 1'b0;
    for (int i = 0; i < N_TRANS; i++) begin
      for (int j = 0; j < N_TRANS; j++) begin
        if (!found && ((int'(rr_ptr) + i) % N_TRANS) == j && enable[j]) begin
          found   = 1'b1;
          ptr_nxt = MSFSM_PTR_W'((j + 1) % N_TRANS);
        end
      end
    end
  end

  // Register grant pulses, the one-cycle lockout and the round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      tb_grant_o <= '0;
      lockout    <= '0;
      rr_ptr     <= '0;
    end else begin
      tb_grant_o <= select;
      lockout    <= lock_nxt;
      if (select != '0) rr_ptr <= ptr_nxt;
    end
  end

  assign busy_o = (lockout != '0);

`ifdef MSFSM_TB_WATCHDOG_EN
  localparam logic [MSFSM_WD_W-1:0] WD_LIMIT_C = MSFSM_WD_W'(WD_LIMIT);

  logic [MSFSM_WD_W-1:0] wd_cnt;
  logic [MSFSM_WD_W-1:0] wd_cnt_nxt;
  logic                  deadlock_q;

  // A stall is a cycle with requests pending and nothing granted at its edge.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (req_i == '0 || select != '0) begin
      wd_cnt_nxt = '0;
    end else if (wd_cnt != '1) begin
      wd_cnt_nxt = wd_cnt + 1'b1;
    end
  end

  // Saturating stall counter with a sticky deadlock flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt     <= '0;
      deadlock_q <= 1'b0;
    end else begin
      wd_cnt     <= wd_cnt_nxt;
      deadlock_q <= deadlock_q | (wd_cnt_nxt >= WD_LIMIT_C);
    end
  end

  assign deadlock_o = deadlock_q;
`else
  assign deadlock_o = 1'b0;
`endif

endmodule : msfsm_tb_arbiter

// File: tb/tb_msfsm_tb_arbiter.sv
// Directed self-checking bench for msfsm_tb_arbiter. Four instances cover
// the shared-place alternation, parallel grants, partial marking, the
// watchdog and a two-FSM token model closed through the arbiter.
module tb_msfsm_tb_arbiter;

  logic clk = 1'b0;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instance A: two transitions sharing place 0.
  logic [7:0] place_a;
  logic [1:0] req_a, grant_a;
  logic       busy_a, dl_a;

  // Instance B: two independent transitions on places 0 and 1.
  logic [7:0] place_b;
  logic [1:0] req_b, grant_b;
  logic       busy_b, dl_b;

  // Instance C: one transition needing places 0 and 1, short watchdog.
  logic [7:0] place_c;
  logic [0:0] req_c, grant_c;
  logic       busy_c, dl_c;

  // Instance D: two cooperating FSMs, A on places 3/4 and B on places 5/6.
  logic [7:0] place_d;
  logic [2:0] req_d, grant_d;
  logic       busy_d, dl_d;

  msfsm_tb_arbiter #(
    .N_TRANS (2), .N_PLACES (8), .PRE_MASK ({8'h01, 8'h01}), .WD_LIMIT (255)
  ) dut_a (
    .clk (clk), .reset (reset), .place_i (place_a), .req_i (req_a),
    .tb_grant_o (grant_a), .busy_o (busy_a), .deadlock_o (dl_a)
  );

  msfsm_tb_arbiter #(
    .N_TRANS (2), .N_PLACES (8), .PRE_MASK ({8'h02, 8'h01}), .WD_LIMIT (255)
  ) dut_b (
    .clk (clk), .reset (reset), .place_i (place_b), .req_i (req_b),
    .tb_grant_o (grant_b), .busy_o (busy_b), .deadlock_o (dl_b)
  );

  msfsm_tb_arbiter #(
    .N_TRANS (1), .N_PLACES (8), .PRE_MASK (8'h03), .WD_LIMIT (4)
  ) dut_c (
    .clk (clk), .reset (reset), .place_i (place_c), .req_i (req_c),
    .tb_grant_o (grant_c), .busy_o (busy_c), .deadlock_o (dl_c)
  );

  // t0: shared sync 3+5 -> 4+6, t1: FSM A 4 -> 3, t2: FSM B 6 -> 5.
  msfsm_tb_arbiter #(
    .N_TRANS (3), .N_PLACES (8), .PRE_MASK ({8'h40, 8'h10, 8'h28}), .WD_LIMIT (255)
  ) dut_d (
    .clk (clk), .reset (reset), .place_i (place_d), .req_i (req_d),
    .tb_grant_o (grant_d), .busy_o (busy_d), .deadlock_o (dl_d)
  );

  // Token model of the two FSMs: a granted transition consumes its preset
  // places and marks its postset at the edge closing the grant cycle.
  logic [7:0] marking;
  always @(posedge clk) begin
    if (reset) begin
      marking <= 8'h28;
    end else begin
      marking <= (marking
                  & ~(grant_d[0] ? 8'h28 : 8'h00)
                  & ~(grant_d[1] ? 8'h10 : 8'h00)
                  & ~(grant_d[2] ? 8'h40 : 8'h00))
                 | (grant_d[0] ? 8'h50 : 8'h00)
                 | (grant_d[1] ? 8'h08 : 8'h00)
                 | (grant_d[2] ? 8'h20 : 8'h00);
    end
  end
  assign place_d = marking;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [1:0] exp_a [1:5];
  logic [2:0] exp_gd [1:8];
  logic [7:0] exp_md [1:8];
  logic       wd_exp;

  initial begin
    exp_a  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_gd = '{3'b001, 3'b000, 3'b110, 3'b000, 3'b001, 3'b000, 3'b110, 3'b000};
    exp_md = '{8'h28, 8'h50, 8'h50, 8'h28, 8'h28, 8'h50, 8'h50, 8'h28};

    reset   = 1'b1;
    place_a = '0; req_a = '0;
    place_b = '0; req_b = '0;
    place_c = '0; req_c = '0;
    req_d   = '0;
    tick();
    tick();

    // Reset state.
    check("rst.grant_a", 32'(grant_a), 32'h0);
    check("rst.busy_a",  32'(busy_a),  32'h0);
    check("rst.grant_b", 32'(grant_b), 32'h0);
    check("rst.dl_c",    32'(dl_c),    32'h0);
    reset = 1'b0;

    // Shared place: grants alternate t0, t1, t0 with lockout cycles between.
    place_a = 8'h01;
    req_a   = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("alt.grant[%0d]", k), 32'(grant_a), 32'(exp_a[k]));
      check($sformatf("alt.busy[%0d]", k),  32'(busy_a),  32'(exp_a[k] != 2'b00));
    end
    tick();
    check("alt.grant[6]", 32'(grant_a), 32'h0);

    // t1 is being registered now; reset at this edge must suppress it.
    reset = 1'b1;
    tick();
    check("rst_mid.grant", 32'(grant_a), 32'h0);
    check("rst_mid.busy",  32'(busy_a),  32'h0);
    reset = 1'b0;
    tick();
    // rr_ptr back at 0, so t0 wins rather than t1.
    check("rst_mid.ptr0_grant", 32'(grant_a), 32'h1);
    check("rst_mid.busy_after", 32'(busy_a),  32'h1);
    tick();
    check("alt.lock_after_rst", 32'(grant_a), 32'h0);

    // Dropping req in the cycle the grant appears does not cancel it.
    tick();
    req_a = 2'b00;
    #1;
    check("req_drop.grant", 32'(grant_a), 32'h2);
    tick();
    check("req_drop.next",  32'(grant_a), 32'h0);
    check("req_drop.busy",  32'(busy_a),  32'h0);

    // Disjoint presets: both granted together, then locked, then again.
    place_b = 8'h03;
    req_b   = 2'b11;
    tick();
    check("par.grant1", 32'(grant_b), 32'h3);
    check("par.busy1",  32'(busy_b),  32'h1);
    tick();
    check("par.grant2", 32'(grant_b), 32'h0);
    check("par.busy2",  32'(busy_b),  32'h0);
    tick();
    check("par.grant3", 32'(grant_b), 32'h3);
    place_b = 8'h01;
    tick();
    check("par.lock",   32'(grant_b), 32'h0);
    tick();
    check("par.only_t0", 32'(grant_b), 32'h1);
    req_b = 2'b00;

    // Partially marked preset: no grant until both places are set.
    place_c = 8'h01;
    req_c   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("partial.grant[%0d]", k), 32'(grant_c), 32'h0);
    end
    place_c = 8'h03;
    tick();
    check("partial.grant_full", 32'(grant_c), 32'h1);
    check("partial.busy",       32'(busy_c),  32'h1);
    check("partial.no_dl",      32'(dl_c),    32'h0);
    req_c   = 1'b0;
    place_c = 8'h00;
    tick();
    check("partial.after", 32'(grant_c), 32'h0);

    // Watchdog: permanent stall with WD_LIMIT = 4.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    place_c = 8'h00;
    req_c   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
`ifdef MSFSM_TB_WATCHDOG_EN
      wd_exp = (k >= 4);
`else
      wd_exp = 1'b0;
`endif
      check($sformatf("wd.deadlock[%0d]", k), 32'(dl_c), 32'(wd_exp));
    end
    req_c = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
`ifdef MSFSM_TB_WATCHDOG_EN
      wd_exp = 1'b1;
`else
      wd_exp = 1'b0;
`endif
      check($sformatf("wd.sticky[%0d]", k), 32'(dl_c), 32'(wd_exp));
    end

    // Two cooperating FSMs from marking 8'h28.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_d = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("fsm.grant[%0d]", k),   32'(grant_d), 32'(exp_gd[k]));
      check($sformatf("fsm.marking[%0d]", k), 32'(marking), 32'(exp_md[k]));
    end
    req_d = 3'b000;
    check("fsm.no_dl", 32'(dl_d), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_msfsm_tb_arbiter
